// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC, req/ack instruction fetch, IR issue and redirect with squash; IFU_PERF_CNT_EN adds issue_count.
module instruction_fetch_unit #(
  parameter int PC_W = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     ir,
  output logic [PC_W-1:0] ir_pc,
  output logic            ir_valid,
  input  logic            dec_ready,
  input  logic            br_valid,
  input  logic [1:0]      br_bs,
  input  logic            br_ps,
  input  logic            br_zero,
  input  logic [PC_W-1:0] br_pc,
  input  logic [PC_W-1:0] br_offset,
  input  logic [PC_W-1:0] br_rega
`ifdef IFU_PERF_CNT_EN
  ,output logic [31:0]    issue_count
`endif
);
  typedef enum logic {FETCH, ISSUE} state_t;
  state_t state, state_n;
  logic [PC_W-1:0] pc, pc_n, ir_pc_n, target;
  logic [31:0] ir_n;
  logic ir_valid_n, squash, squash_n, taken, fire;
  always_comb begin
    taken = br_valid & ((br_bs == 2'b01 & (br_zero ^ br_ps)) | br_bs[1]);
    target = br_bs == 2'b10 ? br_rega : br_pc + br_offset;
    fire = imem_req & imem_ack;
  end
  // A redirect while a request is outstanding keeps the old address on the bus until the ack retires it.
  always_comb begin
    state_n = state;
    pc_n = pc;
    ir_n = ir;
    ir_pc_n = ir_pc;
    ir_valid_n = ir_valid;
    squash_n = squash;
    if (state == FETCH) begin
      if (fire) begin
        squash_n = 1'b0;
        if (taken) pc_n = target;
        else if (!squash) begin
          ir_n = imem_rdata;
          ir_pc_n = pc;
          ir_valid_n = 1'b1;
          pc_n = pc + 1'b1;
          state_n = ISSUE;
        end
      end else if (taken) begin
        pc_n = target;
        squash_n = imem_req;
      end
    end else if (taken || dec_ready) begin
      ir_valid_n = 1'b0;
      state_n = FETCH;
      pc_n = taken ? target : pc;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= FETCH;
      pc <= RESET_PC;
      ir <= 32'h0;
      ir_pc <= '0;
      ir_valid <= 1'b0;
      squash <= 1'b0;
      imem_req <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      state <= state_n;
      pc <= pc_n;
      ir <= ir_n;
      ir_pc <= ir_pc_n;
      ir_valid <= ir_valid_n;
      squash <= squash_n;
      imem_req <= state_n == FETCH;
      imem_addr <= squash_n ? imem_addr : pc_n;
    end
`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) issue_count <= 32'd0;
    else if (ir_valid && dec_ready) issue_count <= issue_count + 32'd1;
`endif
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed stimulus with a scoreboard queue checked by an issue monitor.
module tb_instruction_fetch_unit;
  logic clk = 0, rst = 1;
  logic imem_req, imem_ack, ir_valid, dec_ready, br_valid, br_ps, br_zero;
  logic [15:0] imem_addr, ir_pc, br_pc, br_offset, br_rega;
  logic [31:0] imem_rdata, ir;
  logic [1:0] br_bs;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] issue_count;
`endif
  logic [47:0] exp_q[$];
  logic [47:0] e;
  int n_total = 0, n_pass = 0, n;

  instruction_fetch_unit dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .dec_ready(dec_ready),
    .br_valid(br_valid), .br_bs(br_bs), .br_ps(br_ps), .br_zero(br_zero), .br_pc(br_pc),
    .br_offset(br_offset), .br_rega(br_rega)
`ifdef IFU_PERF_CNT_EN
    , .issue_count(issue_count)
`endif
  );

  always #5 clk = ~clk;
  assign imem_rdata = {16'hC0DE, imem_addr};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic wait_req(output int cnt);
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!imem_req && cnt < 20);
    chk("req_seen", {31'b0, imem_req}, 1);
  endtask

  task automatic push(input logic [15:0] a);
    exp_q.push_back({16'hC0DE, a, a});
  endtask

  always @(negedge clk)
    if (!rst && ir_valid && dec_ready) begin
      if (exp_q.size() == 0) chk("issue_with_empty_queue", 0, 1);
      else begin
        e = exp_q.pop_front();
        chk("ir", ir, e[47:16]);
        chk("ir_pc", {16'b0, ir_pc}, {16'b0, e[15:0]});
      end
    end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    imem_ack = 0; dec_ready = 0; br_valid = 0; br_bs = 0; br_ps = 0; br_zero = 0;
    br_pc = 0; br_offset = 0; br_rega = 0;
    repeat (2) @(negedge clk);
    chk("rst_req", {31'b0, imem_req}, 0);
    chk("rst_addr", {16'b0, imem_addr}, 0);
    chk("rst_ir", ir, 0);
    chk("rst_ir_pc", {16'b0, ir_pc}, 0);
    chk("rst_valid", {31'b0, ir_valid}, 0);
`ifdef IFU_PERF_CNT_EN
    chk("rst_count", issue_count, 0);
`endif
    @(posedge clk) #1; rst = 0; imem_ack = 1; dec_ready = 1;
    wait_req(n);
    chk("stream_addr", {16'b0, imem_addr}, 0);
    push(0);
    for (int i = 1; i < 4; i++) begin
      wait_req(n);
      chk("stream_gap", n, 2);
      chk("stream_addr", {16'b0, imem_addr}, i);
      push(16'(i));
    end
    @(posedge clk) #1; dec_ready = 0;
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid", {31'b0, ir_valid}, 1);
      chk("stall_req", {31'b0, imem_req}, 0);
      chk("stall_ir", ir, 32'hC0DE0003);
    end
    @(posedge clk) #1; dec_ready = 1;
    wait_req(n);
    chk("stall_gap", n, 2);
    chk("after_stall_addr", {16'b0, imem_addr}, 4);
    push(4);
    @(posedge clk) #1; br_valid = 1; br_bs = 2'b01; br_ps = 0; br_zero = 1; br_pc = 16'd10; br_offset = 16'hFFFD;
    @(posedge clk) #1; br_valid = 0;
    wait_req(n);
    chk("bz_latency", n, 1);
    chk("bz_taken_addr", {16'b0, imem_addr}, 7);
    push(7);
    @(posedge clk) #1; br_valid = 1; br_bs = 2'b01; br_zero = 0;
    @(posedge clk) #1; br_valid = 0;
    wait_req(n);
    chk("bz_not_taken_addr", {16'b0, imem_addr}, 8);
    push(8);
    @(posedge clk) #1; imem_ack = 0;
    @(posedge clk) #1; br_valid = 1; br_bs = 2'b10; br_rega = 16'h0040;
    @(negedge clk); chk("jmr_out_addr", {16'b0, imem_addr}, 9);
    @(posedge clk) #1; br_valid = 0;
    @(negedge clk); chk("jmr_hold1", {16'b0, imem_addr}, 9);
    @(posedge clk) #1;
    @(negedge clk); chk("jmr_hold2", {16'b0, imem_addr}, 9);
    @(posedge clk) #1; imem_ack = 1;
    @(negedge clk); chk("jmr_no_valid", {31'b0, ir_valid}, 0);
    wait_req(n);
    chk("jmr_latency", n, 1);
    chk("jmr_addr", {16'b0, imem_addr}, 32'h40);
    push(16'h0040);
    @(posedge clk) #1; br_valid = 1; br_bs = 2'b11; br_pc = 16'hFFFF; br_offset = 16'd2;
    @(posedge clk) #1; br_valid = 0;
    wait_req(n);
    chk("jmp_wrap_addr", {16'b0, imem_addr}, 1);
    push(1);
    @(posedge clk) #1;
    @(posedge clk) #1; br_valid = 1; br_bs = 2'b11; br_pc = 16'h0020; br_offset = 16'h0010;
    @(negedge clk); chk("coinc_addr", {16'b0, imem_addr}, 2);
    @(posedge clk) #1; br_valid = 0;
    @(negedge clk);
    chk("coinc_req", {31'b0, imem_req}, 1);
    chk("coinc_target", {16'b0, imem_addr}, 32'h30);
    chk("coinc_no_valid", {31'b0, ir_valid}, 0);
    push(16'h0030);
    @(posedge clk) #1; imem_ack = 0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_req", {31'b0, imem_req}, 1);
    chk("mid_addr", {16'b0, imem_addr}, 32'h31);
`ifdef IFU_PERF_CNT_EN
    chk("count_before_rst", issue_count, 10);
`endif
    #1; rst = 1; imem_ack = 1;
    #1;
    chk("arst_req", {31'b0, imem_req}, 0);
    chk("arst_addr", {16'b0, imem_addr}, 0);
    chk("arst_ir", ir, 0);
    chk("arst_ir_pc", {16'b0, ir_pc}, 0);
    chk("arst_valid", {31'b0, ir_valid}, 0);
`ifdef IFU_PERF_CNT_EN
    chk("arst_count", issue_count, 0);
`endif
    @(posedge clk) #1; rst = 0;
    @(negedge clk);
    chk("post_rst_req", {31'b0, imem_req}, 0);
    chk("post_rst_valid", {31'b0, ir_valid}, 0);
    wait_req(n);
    chk("post_rst_latency", n, 1);
    chk("post_rst_addr", {16'b0, imem_addr}, 0);
    push(0);
    for (int i = 1; i < 3; i++) begin
      wait_req(n);
      chk("post_rst_gap", n, 2);
      chk("post_rst_addr", {16'b0, imem_addr}, i);
      push(16'(i));
    end
    @(negedge clk);
    @(negedge clk);
`ifdef IFU_PERF_CNT_EN
    chk("count_three", issue_count, 3);
`endif
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
